// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery reduction datapath.
package mont_pkg;

    localparam int unsigned LEN_W     = 8;
    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/mont_reduce_if.sv
// Start/end handshake and operand bus of the Montgomery reduction block.
interface mont_reduce_if
    import mont_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             mr_start;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] num_in;
    logic [WIDTH-1:0] modulus;
    logic             mr_end;
    logic [WIDTH-1:0] mr_out;
    logic             mr_err;

    modport master (
        output mr_start, len, num_in, modulus,
        input  mr_end, mr_out, mr_err
    );

    modport slave (
        input  mr_start, len, num_in, modulus,
        output mr_end, mr_out, mr_err
    );

endinterface

// File: rtl/mont_half_step.sv
// One Montgomery halving step: acc[0] ? (acc + n) / 2 : acc / 2.
module mont_half_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] res
);

    logic [WIDTH:0] sum;

    // Carry is kept so that acc + n never wraps before the halving.
    assign sum = {1'b0, acc} + {1'b0, n};
    assign res = acc[0] ? WIDTH'(sum >> 1) : (acc >> 1);

endmodule

// File: rtl/mont_reduce.sv
// Bit-serial conversion out of the Montgomery domain: mr_out = num_in * 2^-len mod modulus.
// Define MONT_REDUCE_CHECK_EN to reject even moduli and num_in >= modulus with mr_err.
module mont_reduce
    import mont_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    mont_reduce_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             end_q, end_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] half_res;
    logic             err_d;

    mont_half_step #(
        .WIDTH (WIDTH)
    ) u_half_step (
        .acc (acc_q),
        .n   (n_q),
        .res (half_res)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        end_d   = 1'b0;
        out_d   = out_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.mr_start) begin
                    acc_d   = bus.num_in;
                    n_d     = bus.modulus;
                    cnt_d   = bus.len;
                    state_d = (bus.len == '0) ? StFix : StRun;
`ifdef MONT_REDUCE_CHECK_EN
                    if (!bus.modulus[0] || (bus.num_in >= bus.modulus)) begin
                        state_d = StDone;
                        end_d   = 1'b1;
                        err_d   = 1'b1;
                        out_d   = '0;
                    end
`endif
                end
            end
            StRun: begin
                acc_d = half_res;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LEN_W'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // acc < 2N holds throughout, so one subtract fully reduces it.
                out_d   = ({1'b0, acc_q} >= {1'b0, n_q}) ? (acc_q - n_q) : acc_q;
                end_d   = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            end_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            out_q   <= out_d;
        end
    end

`ifdef MONT_REDUCE_CHECK_EN
    logic err_q;

    // The flag is held until the next accepted start re-evaluates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && bus.mr_start) begin
            err_q <= err_d;
        end
    end

    assign bus.mr_err = err_q;
`else
    assign bus.mr_err = err_d & 1'b0;
`endif

    assign bus.mr_end = end_q;
    assign bus.mr_out = out_q;

endmodule

// File: tb/tb_mont_reduce.sv
// Randomized self-checking bench for mont_reduce against a modular-inverse reference model.
module tb_mont_reduce;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] prev_exp;

    mont_reduce_if #(.WIDTH(32)) bus ();

    mont_reduce #(
        .WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // x * 2^len == num (mod n): multiply num by ((n+1)/2)^len, the len-th power of 1/2 mod n.
    function automatic logic [31:0] ref_out(input logic [31:0] num, input logic [31:0] n,
                                            input int l);
        longint unsigned m, h, p;
        m = {32'd0, n};
        h = ((m + 1) / 2) % m;
        p = 1 % m;
        for (int i = 0; i < l; i++) p = (p * h) % m;
        return 32'(({32'd0, num} * p) % m);
    endfunction

    function automatic bit ref_err(input logic [31:0] num, input logic [31:0] n);
`ifdef MONT_REDUCE_CHECK_EN
        return (n[0] == 1'b0) || (num >= n);
`else
        return (num != num);
`endif
    endfunction

    // Starts an op from IDLE, optionally pokes mr_start again mid-op, then checks everything.
    task automatic run_and_check(input logic [31:0] num, input logic [31:0] n,
                                 input logic [7:0] l, input int poke_at);
        logic [31:0] exp_out;
        bit          exp_err;
        int          exp_lat;
        int          lat;

        exp_err = ref_err(num, n);
        exp_out = exp_err ? 32'd0 : ref_out(num, n, int'(l));
        exp_lat = exp_err ? 1 : int'(l) + 2;

        @(negedge clk);
        bus.mr_start = 1'b1;
        bus.num_in   = num;
        bus.modulus  = n;
        bus.len      = l;
        @(posedge clk);
        #1;
        lat          = 1;
        bus.mr_start = 1'b0;
        bus.num_in   = $urandom;
        bus.modulus  = $urandom;
        bus.len      = 8'($urandom);
        if (!exp_err) check("hold", {32'd0, bus.mr_out}, {32'd0, prev_exp});
        while (!bus.mr_end && lat < 400) begin
            if (lat == poke_at) begin
                bus.mr_start = 1'b1;
                bus.num_in   = $urandom;
                bus.modulus  = $urandom | 32'd1;
                bus.len      = 8'($urandom);
            end else begin
                bus.mr_start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.mr_start = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", {32'd0, bus.mr_out}, {32'd0, exp_out});
        check("err", {63'd0, bus.mr_err}, {63'd0, exp_err});
        prev_exp = exp_out;
        @(posedge clk);
        #1;
        check("pulse", {63'd0, bus.mr_end}, 64'd0);
    endtask

    initial begin
        int ends;
        logic [31:0] n;

        n_tests      = 0;
        n_fail       = 0;
        prev_exp     = 32'd0;
        rst          = 1'b1;
        bus.mr_start = 1'b0;
        bus.num_in   = '0;
        bus.modulus  = '0;
        bus.len      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_end", {63'd0, bus.mr_end}, 64'd0);
        check("rst_out", {32'd0, bus.mr_out}, 64'd0);
        check("rst_err", {63'd0, bus.mr_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_and_check(32'd6, 32'd11, 8'd4, -1);
        run_and_check(32'd5, 32'd13, 8'd4, -1);
        run_and_check(32'd3, 32'd7, 8'd0, -1);
        run_and_check(32'd0, 32'd1, 8'd1, -1);
        run_and_check(32'd1, 32'd11, 8'd255, -1);
        run_and_check(32'hFFFF_FFFE, 32'hFFFF_FFFF, 8'd64, -1);
        run_and_check(32'd123456, 32'd1000003, 8'd30, 5);

        // Abort mid-RUN: outputs clear immediately and no completion follows.
        @(negedge clk);
        bus.mr_start = 1'b1;
        bus.num_in   = 32'd7;
        bus.modulus  = 32'd13;
        bus.len      = 8'd30;
        @(posedge clk);
        #1;
        bus.mr_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_end", {63'd0, bus.mr_end}, 64'd0);
        check("abort_out", {32'd0, bus.mr_out}, 64'd0);
        check("abort_err", {63'd0, bus.mr_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_exp = 32'd0;
        ends = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.mr_end) ends++;
        end
        check("abort_no_end", 64'(ends), 64'd0);
        run_and_check(32'd7, 32'd13, 8'd30, -1);

`ifdef MONT_REDUCE_CHECK_EN
        run_and_check(32'd3, 32'd10, 8'd4, -1);
        run_and_check(32'd9, 32'd7, 8'd4, -1);
        run_and_check(32'd0, 32'd0, 8'd2, -1);
        run_and_check(32'd2, 32'd7, 8'd3, -1);
`endif

        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) n = ($urandom_range(1, 200) * 2) + 1;
            else            n = $urandom | 32'd1;
            run_and_check($urandom % n, n, 8'($urandom_range(0, 40)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
